// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave word engine: FSM encodings, mode-field
// positions and the bit-counter sizing helper.
package spi_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Captured mode register layout: {CPOL, CPHA}
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned MODE_CPHA = 0;
  localparam int unsigned MODE_CPOL = 1;

  function automatic int unsigned bit_cnt_width(input int unsigned data_width);
    bit_cnt_width = $clog2(data_width + 32'd1);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises raw SCLK/SS/MOSI into the system clock domain and flags
// SS edges plus SCLK leading/trailing edges relative to the captured CPOL.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sclk,
  input  logic i_ss,
  input  logic i_mosi,
  input  logic i_cpol,
  output logic o_ss_fall_c,
  output logic o_ss_rise_c,
  output logic o_lead_c,
  output logic o_trail_c,
  output logic o_mosi_c
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;
  logic                   w_sclk_s;
  logic                   w_ss_s;
  logic                   w_sclk_tgl;

  // SS resets to its inactive level so reset release never looks like a frame start
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk_s;
      r_ss_d      <= w_ss_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_tgl  = w_sclk_s ^ r_sclk_d;

  assign o_ss_fall_c = r_ss_d & ~w_ss_s;
  assign o_ss_rise_c = ~r_ss_d & w_ss_s;
  assign o_lead_c    = w_sclk_tgl & (w_sclk_s != i_cpol);
  assign o_trail_c   = w_sclk_tgl & (w_sclk_s == i_cpol);
  assign o_mosi_c    = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_word_engine.sv
// SPI slave word engine: all four CPOL/CPHA modes, DATA_WIDTH-bit words,
// multi-word bursts per SS assertion, FIFO-style TX/RX handshakes.
module spi_slave_word_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_SCLK,
  input  logic                  i_SS,
  input  logic                  i_MOSI,
  output logic                  o_MISO,
  output logic                  o_MISO_oe,
  input  logic                  i_CPOL,
  input  logic                  i_CPHA,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_underrun,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_frame_err
);

  localparam int unsigned CNT_W = bit_cnt_width(DATA_WIDTH);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [MODE_W-1:0]     r_mode;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic [DATA_WIDTH-1:0] w_rx_nxt;
  logic [DATA_WIDTH-1:0] w_tx_word;
  logic                  r_need_load;
  logic                  r_fall_pend;
  logic                  w_ss_fall;
  logic                  w_ss_rise;
  logic                  w_lead;
  logic                  w_trail;
  logic                  w_mosi;
  logic                  w_sample_edge;
  logic                  w_shift_edge;
  logic                  w_wrap;
  logic                  w_start;
  logic                  w_capture;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_sample;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_sclk      (i_SCLK),
    .i_ss        (i_SS),
    .i_mosi      (i_MOSI),
    .i_cpol      (r_mode[MODE_CPOL]),
    .o_ss_fall_c (w_ss_fall),
    .o_ss_rise_c (w_ss_rise),
    .o_lead_c    (w_lead),
    .o_trail_c   (w_trail),
    .o_mosi_c    (w_mosi)
  );

  assign w_sample_edge = r_mode[MODE_CPHA] ? w_trail : w_lead;
  assign w_shift_edge  = r_mode[MODE_CPHA] ? w_lead  : w_trail;
  assign w_start       = w_ss_fall | r_fall_pend;
  assign w_cnt_inc     = r_bit_cnt + CNT_W'(1);
  assign w_wrap        = (w_cnt_inc == CNT_W'(DATA_WIDTH));
  assign w_rx_nxt      = MSB_FIRST ? {r_rx_sh[DATA_WIDTH-2:0], w_mosi}
                                   : {w_mosi, r_rx_sh[DATA_WIDTH-1:1]};
  assign w_tx_word     = i_tx_valid ? i_tx_data : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // SS rise has priority over any SCLK edge seen in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_load      = ~r_mode[MODE_CPHA];
          w_state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_DONE;
        end else if (w_sample_edge) begin
          w_sample = 1'b1;
        end else if (w_shift_edge) begin
          w_load  = r_need_load;
          w_shift = ~r_need_load;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_mode      <= '0;
      r_bit_cnt   <= '0;
      r_tx_sh     <= '0;
      r_rx_sh     <= '0;
      r_need_load <= 1'b0;
      r_fall_pend <= 1'b0;
      o_MISO      <= 1'b0;
      o_MISO_oe   <= 1'b0;
      o_tx_ready  <= 1'b0;
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_underrun  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_tx_ready  <= 1'b0;
      o_underrun  <= 1'b0;
      o_rx_valid  <= 1'b0;
      o_busy      <= (w_state_nxt != ST_IDLE);
      o_done      <= (w_state_nxt == ST_DONE);
      o_frame_err <= (w_state_nxt == ST_DONE) && (r_bit_cnt != '0);
      o_MISO_oe   <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_XFER);
      // A new frame start during DONE is held so IDLE can act on it
      r_fall_pend <= (r_state == ST_DONE) & w_ss_fall;

      if (r_state == ST_IDLE) r_bit_cnt <= '0;
      if (w_capture)          r_mode    <= {i_CPOL, i_CPHA};
      if (r_state == ST_ARM)  r_need_load <= r_mode[MODE_CPHA];

      if (w_load) begin
        r_tx_sh     <= w_tx_word;
        o_MISO      <= MSB_FIRST ? w_tx_word[DATA_WIDTH-1] : w_tx_word[0];
        r_need_load <= 1'b0;
        o_tx_ready  <= i_tx_valid;
        o_underrun  <= ~i_tx_valid;
      end else if (w_shift) begin
        if (MSB_FIRST) begin
          r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
          o_MISO  <= r_tx_sh[DATA_WIDTH-2];
        end else begin
          r_tx_sh <= {1'b0, r_tx_sh[DATA_WIDTH-1:1]};
          o_MISO  <= r_tx_sh[1];
        end
      end

      // Word completion wraps the counter and arms a load on the next shift edge
      if (w_sample) begin
        r_rx_sh <= w_rx_nxt;
        if (w_wrap) begin
          o_rx_data   <= w_rx_nxt;
          o_rx_valid  <= 1'b1;
          r_bit_cnt   <= '0;
          r_need_load <= 1'b1;
        end else begin
          r_bit_cnt <= w_cnt_inc;
        end
      end
    end
  end

endmodule
